// File: rtl/waves_nios_jtag_sysclk_cmd_bridge_if.sv
// waves_nios_jtag_sysclk_cmd_bridge_if: JTAG-side inputs and command/pulse outputs of the sysclk bridge
// Optional overrun_cnt member present only when NIOS_JTAG_OVERRUN_CNT_EN is defined.
interface waves_nios_jtag_sysclk_cmd_bridge_if #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2
`ifdef NIOS_JTAG_OVERRUN_CNT_EN
   , parameter int CNT_WIDTH = 8
`endif
);
   logic [IR_WIDTH-1:0]      ir_in;
   logic [DR_WIDTH-1:0]      sr;
   logic                     vs_uir;
   logic                     vs_udr;
   logic                     cmd_ready;
   logic                     overrun_clr;
   logic                     cmd_valid;
   logic [IR_WIDTH-1:0]      cmd_ir;
   logic [DR_WIDTH-1:0]      cmd_data;
   logic [(1<<IR_WIDTH)-1:0] take_action;
   logic [(1<<IR_WIDTH)-1:0] take_no_action;
   logic                     overrun;
`ifdef NIOS_JTAG_OVERRUN_CNT_EN
   logic [CNT_WIDTH-1:0]     overrun_cnt;
`endif
   modport master (
      input  ir_in, sr, vs_uir, vs_udr, cmd_ready, overrun_clr,
      output cmd_valid, cmd_ir, cmd_data, take_action, take_no_action, overrun
`ifdef NIOS_JTAG_OVERRUN_CNT_EN
      , output overrun_cnt
`endif
   );
   modport slave (
      output ir_in, sr, vs_uir, vs_udr, cmd_ready, overrun_clr,
      input  cmd_valid, cmd_ir, cmd_data, take_action, take_no_action, overrun
`ifdef NIOS_JTAG_OVERRUN_CNT_EN
      , input overrun_cnt
`endif
   );
endinterface

// File: rtl/waves_nios_jtag_sysclk_cmd_bridge.sv
// waves_nios_jtag_sysclk_cmd_bridge: syncs TCK-domain UIR/UDR strobes, holds one DR command with valid/ready, per-IR action pulses, sticky overrun
// Optional saturating drop counter enabled by NIOS_JTAG_OVERRUN_CNT_EN.
module waves_nios_jtag_sysclk_cmd_bridge #(
   parameter int DR_WIDTH    = 38,
   parameter int IR_WIDTH    = 2,
   parameter int SYNC_STAGES = 2
`ifdef NIOS_JTAG_OVERRUN_CNT_EN
   , parameter int CNT_WIDTH = 8
`endif
) (
   input logic clk,
   input logic reset_n,
   waves_nios_jtag_sysclk_cmd_bridge_if.master bus
);
   localparam int N_CMD = 1 << IR_WIDTH;
   logic [SYNC_STAGES-1:0] r_uir_sync, r_udr_sync, r_prime;
   logic                   r_uir_hist, r_udr_hist;
   logic [IR_WIDTH-1:0]    r_ir, r_cmd_ir;
   logic [DR_WIDTH-1:0]    r_cmd_data;
   logic                   r_cmd_valid, r_overrun;
   logic [N_CMD-1:0]       r_take_action, r_take_no_action;
   logic                   w_uir_ev, w_udr_ev, w_load, w_drop;
   logic [IR_WIDTH-1:0]    w_ir;
   logic [N_CMD-1:0]       w_hot;
   assign w_uir_ev = r_uir_sync[SYNC_STAGES-1] & ~r_uir_hist;
   assign w_udr_ev = r_udr_sync[SYNC_STAGES-1] & ~r_udr_hist;
   assign w_load   = w_udr_ev & (~r_cmd_valid | bus.cmd_ready);
   assign w_drop   = w_udr_ev & r_cmd_valid & ~bus.cmd_ready;
   assign w_ir     = w_uir_ev ? bus.ir_in : r_ir;
   assign w_hot    = {{(N_CMD-1){1'b0}}, 1'b1} << w_ir;
   // Strobe synchronisers; history is held at 1 until the chain carries real samples (r_prime)
   // so a strobe already high at reset release is not mistaken for a fresh edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_uir_sync <= '0;
         r_udr_sync <= '0;
         r_prime    <= '0;
         r_uir_hist <= 1'b1;
         r_udr_hist <= 1'b1;
      end else begin
         r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], bus.vs_uir};
         r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], bus.vs_udr};
         r_prime    <= {r_prime[SYNC_STAGES-2:0], 1'b1};
         r_uir_hist <= r_prime[SYNC_STAGES-1] ? r_uir_sync[SYNC_STAGES-1] : 1'b1;
         r_udr_hist <= r_prime[SYNC_STAGES-1] ? r_udr_sync[SYNC_STAGES-1] : 1'b1;
      end
   end
   // IR latch, one-entry command holder, action pulses and sticky overrun (set beats clear)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ir             <= '0;
         r_cmd_ir         <= '0;
         r_cmd_data       <= '0;
         r_cmd_valid      <= 1'b0;
         r_take_action    <= '0;
         r_take_no_action <= '0;
         r_overrun        <= 1'b0;
      end else begin
         if (w_uir_ev) r_ir <= bus.ir_in;
         if (w_load) begin
            r_cmd_data <= bus.sr;
            r_cmd_ir   <= w_ir;
         end
         r_cmd_valid      <= w_load | (r_cmd_valid & ~bus.cmd_ready);
         r_take_action    <= (w_load &  bus.sr[DR_WIDTH-1]) ? w_hot : '0;
         r_take_no_action <= (w_load & ~bus.sr[DR_WIDTH-1]) ? w_hot : '0;
         r_overrun        <= w_drop | (r_overrun & ~bus.overrun_clr);
      end
   end
`ifdef NIOS_JTAG_OVERRUN_CNT_EN
   logic [CNT_WIDTH-1:0] r_overrun_cnt;
   // Saturating drop counter; a drop coinciding with a clear restarts the count at 1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_overrun_cnt <= '0;
      else if (bus.overrun_clr) r_overrun_cnt <= {{(CNT_WIDTH-1){1'b0}}, w_drop};
      else if (w_drop && !(&r_overrun_cnt)) r_overrun_cnt <= r_overrun_cnt + 1'b1;
   end
   assign bus.overrun_cnt = r_overrun_cnt;
`endif
   assign bus.cmd_valid      = r_cmd_valid;
   assign bus.cmd_ir         = r_cmd_ir;
   assign bus.cmd_data       = r_cmd_data;
   assign bus.take_action    = r_take_action;
   assign bus.take_no_action = r_take_no_action;
   assign bus.overrun        = r_overrun;
endmodule
